// File: rtl/rx_pkg.sv
// Receiver shared definitions: correlation RAM geometry and peak-scan FSM states.
package rx_pkg;

   localparam int RX_ADDR_W = 10;
   localparam int RX_DATA_W = 32;
   localparam int RX_DEPTH  = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rx_peak_state_t;

endpackage

// File: rtl/rx_abs_sat.sv
// Saturating absolute value of a two's complement word. The most negative
// value has no positive counterpart, so it clamps to the largest positive one.
module rx_abs_sat #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] value,
   output logic [DATA_W-1:0] mag
);

   localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

   // Negate negatives, clamp the one value whose negation overflows
   always_comb begin
      mag = value;
      if (value == MIN_NEG)
         mag = MAX_POS;
      else if (value[DATA_W-1])
         mag = ~value + 1'b1;
   end

endmodule

// File: rtl/rx_peak_finder.sv
// Correlation RAM peak scanner. Reads every word once in circular order from
// a caller-supplied base, tracks the largest magnitude and its address, and
// publishes the peak, its index and a threshold-crossing flag.
module rx_peak_finder
   import rx_pkg::*;
#(
   parameter int DEPTH  = RX_DEPTH,
   parameter int ADDR_W = RX_ADDR_W,
   parameter int DATA_W = RX_DATA_W
) (
   input  logic              crx_clk,
   input  logic              rrx_rst,
   input  logic              erx_en,
   input  logic              istart,
   input  logic [ADDR_W-1:0] istart_addr,
   input  logic [DATA_W-1:0] ithreshold,
   output logic              or_enable,
   output logic [ADDR_W-1:0] or_address,
   input  logic [DATA_W-1:0] idata,
   output logic              obusy,
   output logic              odone,
   output logic [DATA_W-1:0] opeak_value,
   output logic [ADDR_W-1:0] opeak_index,
   output logic              opeak_valid
);

   // Index of the final word in a scan; the address counter wraps naturally
   // because DEPTH is a power of two.
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   rx_peak_state_t    state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] thr;

   // Read-data qualifier and address, one cycle behind the RAM request
   logic              rd_vld;
   logic [ADDR_W-1:0] rd_addr;

   // Running maximum for the scan in progress
   logic [DATA_W-1:0] max_mag;
   logic [DATA_W-1:0] max_val;
   logic [ADDR_W-1:0] max_idx;

   // Maximum including the sample arriving this cycle
   logic [DATA_W-1:0] smp_mag;
   logic              take;
   logic [DATA_W-1:0] nxt_mag;
   logic [DATA_W-1:0] nxt_val;
   logic [ADDR_W-1:0] nxt_idx;

   logic              accept;

   assign accept = (state == IDLE) && istart && erx_en;

   rx_abs_sat #(.DATA_W(DATA_W)) u_abs (
      .value (idata),
      .mag   (smp_mag)
   );

   // Strictly greater so the earliest sample in scan order keeps a tie
   always_comb begin
      take    = rd_vld && (smp_mag > max_mag);
      nxt_mag = max_mag;
      nxt_val = max_val;
      nxt_idx = max_idx;
      if (take) begin
         nxt_mag = smp_mag;
         nxt_val = idata;
         nxt_idx = rd_addr;
      end
   end

   // Scan sequencing: state, RAM read port, busy/done flags
   always_ff @(posedge crx_clk) begin
      if (rrx_rst) begin
         state      <= IDLE;
         cnt        <= '0;
         thr        <= '0;
         or_enable  <= 1'b0;
         or_address <= '0;
         obusy      <= 1'b0;
         odone      <= 1'b0;
      end else if (!erx_en) begin
         // Abort: drop the port and return idle without reporting
         state     <= IDLE;
         or_enable <= 1'b0;
         obusy     <= 1'b0;
         odone     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               odone <= 1'b0;
               if (istart) begin
                  state      <= READ;
                  cnt        <= '0;
                  thr        <= ithreshold;
                  or_enable  <= 1'b1;
                  or_address <= istart_addr;
                  obusy      <= 1'b1;
               end
            end
            READ: begin
               if (cnt == LAST) begin
                  state     <= DRAIN;
                  or_enable <= 1'b0;
               end else begin
                  cnt        <= cnt + 1'b1;
                  or_address <= or_address + 1'b1;
               end
            end
            DRAIN: begin
               state <= DONE;
               odone <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               odone <= 1'b0;
               obusy <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               or_enable <= 1'b0;
               obusy     <= 1'b0;
               odone     <= 1'b0;
            end
         endcase
      end
   end

   // Compare pipeline, running max and published results
   always_ff @(posedge crx_clk) begin
      if (rrx_rst) begin
         rd_vld      <= 1'b0;
         rd_addr     <= '0;
         max_mag     <= '0;
         max_val     <= '0;
         max_idx     <= '0;
         opeak_value <= '0;
         opeak_index <= '0;
         opeak_valid <= 1'b0;
      end else begin
         rd_vld  <= or_enable && erx_en;
         rd_addr <= or_address;
         if (accept) begin
            // Empty max points at the base so an all-zero buffer reports it
            max_mag <= '0;
            max_val <= '0;
            max_idx <= istart_addr;
         end else begin
            max_mag <= nxt_mag;
            max_val <= nxt_val;
            max_idx <= nxt_idx;
         end
         // The last sample lands during DRAIN, so publish the merged max
         if (erx_en && (state == DRAIN)) begin
            opeak_value <= nxt_val;
            opeak_index <= nxt_idx;
            opeak_valid <= (nxt_mag >= thr);
         end
      end
   end

endmodule
